i2c_bus_resolver: RTL and testbench

Parametrised multi-device I2C bus resolver and monitor for the Wishbone-I2C verification environment. Wired-AND resolves NUM_DEV open-drain SCL/SDA drivers and feeds the raw resolved lines back to every device. Synchronises and (optionally) glitch-filters the lines, then tracks bus state from them: START/STOP, busy, bit/byte position and per-device arbitration loss. Sits between the I2C master DUT(s) and the slave models.

---
 rtl/i2c_bus_pkg.sv | 6 +
 rtl/i2c_glitch_filt.sv | 41 ++++
 rtl/i2c_bus_resolver.sv | 129 ++++++++++++
 tb/tb_i2c_bus_resolver.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/i2c_bus_pkg.sv
// i2c_bus_pkg: bus monitor state encoding and bit-position constants.
package i2c_bus_pkg;
    typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE} bus_state_e;
    localparam int BIT_CNT_W = 4;
    localparam logic [BIT_CNT_W-1:0] ACK_BIT = 4'd8;
endpackage

// File: rtl/i2c_glitch_filt.sv
// i2c_glitch_filt: synchroniser plus optional glitch filter for one I2C line.
// The filter stage exists only when I2C_BUS_GLITCH_FILT_EN is defined.
module i2c_glitch_filt
    import i2c_bus_pkg::*;
#(
    parameter int SYNC_STAGES = 2
`ifdef I2C_BUS_GLITCH_FILT_EN
    , parameter int FILT_LEN = 3
`endif
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic line_i,
    output logic line_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    always_ff @(posedge clk_i) begin
        sync_q <= !rstn_i ? '1 : {sync_q[SYNC_STAGES-2:0], line_i};
    end
`ifdef I2C_BUS_GLITCH_FILT_EN
    logic       filt_q;
    logic [3:0] cnt_q;
    logic       diff;
    logic       done;
    assign diff = sync_q[SYNC_STAGES-1] ^ filt_q;
    assign done = diff && (cnt_q == 4'(FILT_LEN - 1));
    // cnt_q counts consecutive cycles of disagreement; any agreement restarts it
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            filt_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            filt_q <= done ? ~filt_q : filt_q;
            cnt_q  <= (diff && !done) ? cnt_q + 4'd1 : '0;
        end
    end
    assign line_o = filt_q;
`else
    assign line_o = sync_q[SYNC_STAGES-1];
`endif
endmodule

// File: rtl/i2c_bus_resolver.sv
// i2c_bus_resolver: wired-AND I2C bus model with START/STOP, bit and arbitration monitor.
// Glitch filtering is compiled in with I2C_BUS_GLITCH_FILT_EN.
module i2c_bus_resolver
    import i2c_bus_pkg::*;
#(
    parameter int NUM_DEV     = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic                 WB_CLK_I,
    input  logic                 WB_RSTN_I,
    input  logic [NUM_DEV-1:0]   SCL_PAD_O,
    input  logic [NUM_DEV-1:0]   SCL_PADOEN_O,
    input  logic [NUM_DEV-1:0]   SDA_PAD_O,
    input  logic [NUM_DEV-1:0]   SDA_PADOEN_O,
    input  logic [NUM_DEV-1:0]   ARB_CLR_I,
    output logic                 SCL_PAD_I,
    output logic                 SDA_PAD_I,
    output logic                 SCL_FILT_O,
    output logic                 SDA_FILT_O,
    output logic                 START_O,
    output logic                 STOP_O,
    output logic                 BUSY_O,
    output logic [BIT_CNT_W-1:0] BIT_CNT_O,
    output logic                 BYTE_DONE_O,
    output logic [NUM_DEV-1:0]   ARB_LOST_O
);
`ifdef I2C_BUS_GLITCH_FILT_EN
    localparam int FILT_EN = 1;
`else
    localparam int FILT_EN = 0;
`endif
    localparam int LAT = SYNC_STAGES + FILT_LEN * FILT_EN;
    localparam int SW  = $clog2(LAT + 1);

    assign SCL_PAD_I = &(SCL_PADOEN_O | SCL_PAD_O);
    assign SDA_PAD_I = &(SDA_PADOEN_O | SDA_PAD_O);

    i2c_glitch_filt #(
        .SYNC_STAGES(SYNC_STAGES)
`ifdef I2C_BUS_GLITCH_FILT_EN
        , .FILT_LEN(FILT_LEN)
`endif
    ) u_scl_filt (
        .clk_i(WB_CLK_I), .rstn_i(WB_RSTN_I), .line_i(SCL_PAD_I), .line_o(SCL_FILT_O)
    );

    i2c_glitch_filt #(
        .SYNC_STAGES(SYNC_STAGES)
`ifdef I2C_BUS_GLITCH_FILT_EN
        , .FILT_LEN(FILT_LEN)
`endif
    ) u_sda_filt (
        .clk_i(WB_CLK_I), .rstn_i(WB_RSTN_I), .line_i(SDA_PAD_I), .line_o(SDA_FILT_O)
    );

    // Each device's SDA intent, delayed to line up with SDA_FILT_O
    logic [NUM_DEV-1:0] dly_q [LAT];
    always_ff @(posedge WB_CLK_I) begin
        dly_q[0] <= !WB_RSTN_I ? '1 : (SDA_PADOEN_O | SDA_PAD_O);
        for (int k = 1; k < LAT; k++) dly_q[k] <= !WB_RSTN_I ? '1 : dly_q[k-1];
    end

    bus_state_e         state_q;
    logic               scl_q, sda_q;
    logic [SW-1:0]      settle_q;
    logic [NUM_DEV-1:0] cont_q;
    logic               start_c, stop_c, rise_c;
    logic [NUM_DEV-1:0] lose_c;

    assign start_c = SCL_FILT_O & scl_q & sda_q & ~SDA_FILT_O;
    assign stop_c  = SCL_FILT_O & scl_q & ~sda_q & SDA_FILT_O;
    assign rise_c  = SCL_FILT_O & ~scl_q & (state_q == ACTIVE);
    assign lose_c  = (rise_c && !SDA_FILT_O) ? (cont_q & dly_q[LAT-1]) : '0;

    always_ff @(posedge WB_CLK_I) begin
        if (!WB_RSTN_I) begin
            state_q     <= WAIT_IDLE;
            scl_q       <= 1'b1;
            sda_q       <= 1'b1;
            settle_q    <= '0;
            cont_q      <= '0;
            START_O     <= 1'b0;
            STOP_O      <= 1'b0;
            BUSY_O      <= 1'b0;
            BIT_CNT_O   <= '0;
            BYTE_DONE_O <= 1'b0;
            ARB_LOST_O  <= '0;
        end else begin
            scl_q       <= SCL_FILT_O;
            sda_q       <= SDA_FILT_O;
            START_O     <= 1'b0;
            STOP_O      <= 1'b0;
            BYTE_DONE_O <= 1'b0;
            ARB_LOST_O  <= (ARB_LOST_O & ~ARB_CLR_I) | lose_c;
            case (state_q)
                WAIT_IDLE: begin
                    // The line flops read idle straight out of reset; trust them only once refilled
                    settle_q <= (settle_q == SW'(LAT)) ? settle_q : settle_q + SW'(1);
                    if (settle_q == SW'(LAT) && SCL_FILT_O && SDA_FILT_O) state_q <= IDLE;
                end
                IDLE: begin
                    STOP_O <= stop_c;
                    if (start_c) begin
                        state_q   <= ACTIVE;
                        START_O   <= 1'b1;
                        BUSY_O    <= 1'b1;
                        BIT_CNT_O <= '0;
                    end
                end
                default: begin
                    START_O <= start_c;
                    STOP_O  <= stop_c;
                    cont_q  <= stop_c ? '0 : (cont_q | (~SCL_PADOEN_O & ~SCL_PAD_O));
                    if (start_c || stop_c) begin
                        BIT_CNT_O <= '0;
                    end else if (rise_c) begin
                        BIT_CNT_O   <= (BIT_CNT_O == ACK_BIT) ? '0 : BIT_CNT_O + BIT_CNT_W'(1);
                        BYTE_DONE_O <= (BIT_CNT_O == ACK_BIT);
                    end
                    if (stop_c) begin
                        state_q <= IDLE;
                        BUSY_O  <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_bus_resolver.sv
// tb_i2c_bus_resolver: directed self-checking bench for i2c_bus_resolver.
module tb_i2c_bus_resolver;
    localparam int ND = 2;
`ifdef I2C_BUS_GLITCH_FILT_EN
    localparam int FILT_ON = 1;
`else
    localparam int FILT_ON = 0;
`endif
    localparam int H = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [ND-1:0] scl_o = '1, scl_oen = '1, sda_o = '1, sda_oen = '1, arb_clr = '0;
    logic          scl_i, sda_i, scl_f, sda_f, start, stop, busy, bd;
    logic [3:0]    bit_cnt;
    logic [ND-1:0] arb;
    int            checks = 0, failures = 0;
    int            n_start = 0, n_stop = 0, n_bd = 0;
    int            s0, p0, b0;
    logic          sda_low_seen = 1'b0;
    logic          glitch_armed = 1'b0;
    logic [7:0]    byte_v, byte_w;

    always #5 clk = ~clk;

    i2c_bus_resolver #(.NUM_DEV(ND), .SYNC_STAGES(2), .FILT_LEN(3)) dut (
        .WB_CLK_I(clk), .WB_RSTN_I(rstn),
        .SCL_PAD_O(scl_o), .SCL_PADOEN_O(scl_oen),
        .SDA_PAD_O(sda_o), .SDA_PADOEN_O(sda_oen),
        .ARB_CLR_I(arb_clr),
        .SCL_PAD_I(scl_i), .SDA_PAD_I(sda_i),
        .SCL_FILT_O(scl_f), .SDA_FILT_O(sda_f),
        .START_O(start), .STOP_O(stop), .BUSY_O(busy),
        .BIT_CNT_O(bit_cnt), .BYTE_DONE_O(bd), .ARB_LOST_O(arb)
    );

    always @(negedge clk) begin
        n_start += int'(start);
        n_stop  += int'(stop);
        n_bd    += int'(bd);
        if (glitch_armed && !sda_f) sda_low_seen = 1'b1;
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_scl(logic [ND-1:0] m, logic v);
        for (int d = 0; d < ND; d++) if (m[d]) begin scl_oen[d] = v; scl_o[d] = v; end
        cyc(H);
    endtask

    task automatic set_sda(logic [ND-1:0] m, logic [ND-1:0] v);
        for (int d = 0; d < ND; d++) if (m[d]) begin sda_oen[d] = v[d]; sda_o[d] = v[d]; end
        cyc(H);
    endtask

    task automatic do_start(logic [ND-1:0] m);
        set_sda(m, '0);
        set_scl(m, 1'b0);
    endtask

    task automatic do_stop(logic [ND-1:0] m);
        set_sda(m, '0);
        set_scl(m, 1'b1);
        set_sda(m, '1);
    endtask

    task automatic send_bit(logic [ND-1:0] m, logic [ND-1:0] v);
        set_sda(m, v);
        set_scl(m, 1'b1);
        set_scl(m, 1'b0);
    endtask

    initial begin
        // Reset held with device 0 pulling SDA low
        sda_oen[0] = 1'b0; sda_o[0] = 1'b0;
        cyc(4);
        chk("rst_scl_filt", 32'(scl_f), 32'd1);
        chk("rst_sda_filt", 32'(sda_f), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_bit_cnt", 32'(bit_cnt), 32'd0);
        chk("rst_pulses", {29'd0, start, stop, bd}, 32'd0);
        chk("rst_arb", 32'(arb), 32'd0);
        chk("raw_sda_low", 32'(sda_i), 32'd0);
        chk("raw_scl_high", 32'(scl_i), 32'd1);
        rstn = 1'b1;
        cyc(H);
        chk("wait_sda_filt", 32'(sda_f), 32'd0);
        set_sda(2'b01, 2'b11);
        chk("wait_no_start", 32'(n_start), 32'd0);
        chk("wait_no_stop", 32'(n_stop), 32'd0);
        chk("wait_busy", 32'(busy), 32'd0);
        chk("idle_sda_filt", 32'(sda_f), 32'd1);

        // Two-cycle SDA glitch while SCL is high
        s0 = n_start; p0 = n_stop;
        glitch_armed = 1'b1;
        sda_oen[0] = 1'b0; sda_o[0] = 1'b0;
        cyc(2);
        sda_oen[0] = 1'b1; sda_o[0] = 1'b1;
        cyc(H);
        glitch_armed = 1'b0;
        chk("glitch_sda_seen", 32'(sda_low_seen), FILT_ON ? 32'd0 : 32'd1);
        chk("glitch_start", 32'(n_start - s0), FILT_ON ? 32'd0 : 32'd1);
        chk("glitch_stop", 32'(n_stop - p0), FILT_ON ? 32'd0 : 32'd1);
        chk("glitch_busy", 32'(busy), 32'd0);

        // Device 0: START, 0xA5, NACK, STOP
        s0 = n_start; p0 = n_stop; b0 = n_bd;
        do_start(2'b01);
        chk("a5_start", 32'(n_start - s0), 32'd1);
        chk("a5_busy", 32'(busy), 32'd1);
        chk("a5_cnt0", 32'(bit_cnt), 32'd0);
        byte_v = 8'hA5;
        for (int k = 1; k <= 8; k++) begin
            send_bit(2'b01, {1'b1, byte_v[8-k]});
            chk("a5_bit_cnt", 32'(bit_cnt), 32'(k));
        end
        chk("a5_no_bd", 32'(n_bd - b0), 32'd0);
        send_bit(2'b01, 2'b11);
        chk("a5_ack_cnt", 32'(bit_cnt), 32'd0);
        chk("a5_byte_done", 32'(n_bd - b0), 32'd1);
        chk("a5_arb", 32'(arb), 32'd0);
        do_stop(2'b01);
        chk("a5_stop", 32'(n_stop - p0), 32'd1);
        chk("a5_start_once", 32'(n_start - s0), 32'd1);
        chk("a5_busy_end", 32'(busy), 32'd0);
        chk("a5_cnt_end", 32'(bit_cnt), 32'd0);

        // Repeated START after a full 9-bit frame
        s0 = n_start; b0 = n_bd;
        do_start(2'b01);
        byte_v = 8'h3C;
        for (int k = 1; k <= 8; k++) send_bit(2'b01, {1'b1, byte_v[8-k]});
        send_bit(2'b01, 2'b11);
        chk("rs_byte_done", 32'(n_bd - b0), 32'd1);
        set_sda(2'b01, 2'b11);
        set_scl(2'b01, 1'b1);
        chk("rs_pre_cnt", 32'(bit_cnt), 32'd1);
        set_sda(2'b01, 2'b10);
        chk("rs_start", 32'(n_start - s0), 32'd2);
        chk("rs_busy", 32'(busy), 32'd1);
        chk("rs_cnt", 32'(bit_cnt), 32'd0);
        set_scl(2'b01, 1'b0);
        do_stop(2'b01);
        chk("rs_busy_end", 32'(busy), 32'd0);

        // Arbitration: dev0 sends 0x50, dev1 0x40; dev0 releases at bit 4 while SDA is 0
        b0 = n_bd;
        do_start(2'b11);
        byte_v = 8'h50; byte_w = 8'h40;
        for (int k = 1; k <= 8; k++) begin
            send_bit(2'b11, {byte_w[8-k], (k >= 4) ? 1'b1 : byte_v[8-k]});
            chk("arb_bit", 32'(arb), (k >= 4) ? 32'd1 : 32'd0);
        end
        send_bit(2'b11, 2'b11);
        chk("arb_byte_done", 32'(n_bd - b0), 32'd1);
        do_stop(2'b11);
        chk("arb_sticky", 32'(arb), 32'd1);
        arb_clr = 2'b10;
        cyc(2);
        chk("arb_clr_other", 32'(arb), 32'd1);
        arb_clr = 2'b01;
        cyc(1);
        arb_clr = 2'b00;
        cyc(1);
        chk("arb_cleared", 32'(arb), 32'd0);

        // Reset mid-byte
        do_start(2'b01);
        for (int k = 1; k <= 5; k++) send_bit(2'b01, 2'b11);
        chk("mid_cnt5", 32'(bit_cnt), 32'd5);
        chk("mid_busy", 32'(busy), 32'd1);
        rstn = 1'b0;
        cyc(1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_cnt", 32'(bit_cnt), 32'd0);
        chk("mid_rst_scl_filt", 32'(scl_f), 32'd1);
        chk("mid_rst_sda_filt", 32'(sda_f), 32'd1);
        chk("mid_rst_pulses", {29'd0, start, stop, bd}, 32'd0);
        scl_oen = '1; scl_o = '1; sda_oen = '1; sda_o = '1;
        cyc(2);
        rstn = 1'b1;
        cyc(H);
        s0 = n_start;
        do_start(2'b01);
        chk("post_rst_start", 32'(n_start - s0), 32'd1);
        do_stop(2'b01);
        chk("post_rst_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
